// File: rtl/tl_controller_param.sv
// Two-road (NS/EW) traffic-light controller with parametrised phase timing,
// latched pedestrian service with walk/clearance, and a night flashing mode.
module tl_controller_param #(
   parameter int GREEN_T  = 8,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int WALK_T   = 4,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       res,
   input  logic       ped_ns_req,
   input  logic       ped_ew_req,
   input  logic       night,
   output logic [2:0] NS,
   output logic [2:0] EW,
   output logic [2:0] P_NS,
   output logic [2:0] P_EW,
   output logic       ped_ns_ack,
   output logic       ped_ew_ack
);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR_EW = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR_NS = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [CW-1:0] G_LAST = CW'(GREEN_T - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] A_LAST = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] WALK_C = CW'(WALK_T);
   localparam logic [CW-1:0] T_ONE  = CW'(1);

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;
   localparam logic [2:0] PED_STOP = 3'b100;
   localparam logic [2:0] PED_CLR  = 3'b010;
   localparam logic [2:0] PED_WALK = 3'b001;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] timer;
   logic          last;
   logic          enter_ns;
   logic          enter_ew;
   logic          pend_ns;
   logic          pend_ew;
   logic          served_ns;
   logic          served_ew;
   logic          flash_tgl;
   logic [2:0]    ns_d;
   logic [2:0]    ew_d;
   logic [2:0]    p_ns_d;
   logic [2:0]    p_ew_d;
   logic          ack_ns_d;
   logic          ack_ew_d;

   // night is only looked at on the final all-red cycle, so a green is never cut short
   always_comb begin
      last       = 1'b0;
      next_state = state;
      case (state)
         NS_G:  begin last = (timer == G_LAST); if (last) next_state = NS_Y;  end
         NS_Y:  begin last = (timer == Y_LAST); if (last) next_state = AR_EW; end
         AR_EW: begin
            last = (timer == A_LAST);
            if (last) next_state = night ? FLASH : EW_G;
         end
         EW_G:  begin last = (timer == G_LAST); if (last) next_state = EW_Y;  end
         EW_Y:  begin last = (timer == Y_LAST); if (last) next_state = AR_NS; end
         AR_NS: begin
            last = (timer == A_LAST);
            if (last) next_state = night ? FLASH : NS_G;
         end
         FLASH: if (!night) next_state = AR_NS;
         default: next_state = AR_NS;
      endcase
      enter_ns = (next_state == NS_G) && (state != NS_G);
      enter_ew = (next_state == EW_G) && (state != EW_G);
   end

   always_comb begin
      ns_d     = LAMP_R;
      ew_d     = LAMP_R;
      p_ns_d   = PED_STOP;
      p_ew_d   = PED_STOP;
      ack_ns_d = 1'b0;
      ack_ew_d = 1'b0;
      case (state)
         NS_G: begin
            ns_d = LAMP_G;
            if (served_ns) begin
               p_ns_d   = (timer < WALK_C) ? PED_WALK : PED_CLR;
               ack_ns_d = (timer == '0);
            end
         end
         NS_Y: ns_d = LAMP_Y;
         EW_G: begin
            ew_d = LAMP_G;
            if (served_ew) begin
               p_ew_d   = (timer < WALK_C) ? PED_WALK : PED_CLR;
               ack_ew_d = (timer == '0);
            end
         end
         EW_Y: ew_d = LAMP_Y;
         FLASH: begin
            ns_d = flash_tgl ? LAMP_OFF : LAMP_Y;
            ew_d = flash_tgl ? LAMP_OFF : LAMP_Y;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state      <= AR_NS;
         timer      <= '0;
         pend_ns    <= 1'b0;
         pend_ew    <= 1'b0;
         served_ns  <= 1'b0;
         served_ew  <= 1'b0;
         flash_tgl  <= 1'b0;
         NS         <= LAMP_R;
         EW         <= LAMP_R;
         P_NS       <= PED_STOP;
         P_EW       <= PED_STOP;
         ped_ns_ack <= 1'b0;
         ped_ew_ack <= 1'b0;
      end else begin
         state     <= next_state;
         timer     <= (next_state != state) ? '0 : timer + T_ONE;
         flash_tgl <= (state == FLASH && next_state == FLASH) ? ~flash_tgl : 1'b0;
         // a request on the entry cycle itself is kept for the following green
         pend_ns   <= ped_ns_req | (pend_ns & ~enter_ns);
         pend_ew   <= ped_ew_req | (pend_ew & ~enter_ew);
         if (enter_ns) served_ns <= pend_ns;
         if (enter_ew) served_ew <= pend_ew;
         NS         <= ns_d;
         EW         <= ew_d;
         P_NS       <= p_ns_d;
         P_EW       <= p_ew_d;
         ped_ns_ack <= ack_ns_d;
         ped_ew_ack <= ack_ew_d;
      end
   end

endmodule

// File: doc/tl_controller_param.md
# tl_controller_param

Parametrised two-road traffic-light controller for a single NS/EW intersection. It succeeds the fixed-timing `tl_controler`. Green, yellow, all-red and walk durations are set by parameters. Pedestrian requests are latched and served with walk and clearance indications, and a night mode gives flashing yellow. It drives the lamp outputs directly and is the top of the TLC FSM subtree.

## Interface
- `GREEN_T`, 8: cycles of green per road
- `YELLOW_T`, 3: cycles of yellow per road
- `ALLRED_T`, 1: cycles of all-red between road changes
- `WALK_T`, 4: cycles of steady walk at the start of a served green; must be < `GREEN_T`
- `CW`, 8: timer width; every duration must be ≤ 2^CW − 1

- `clk` in 1: clock, rising edge
- `res` in 1: reset, asynchronous, active-high
- `ped_ns_req` in 1: pedestrian request to cross with NS traffic; level or pulse
- `ped_ew_req` in 1: pedestrian request to cross with EW traffic
- `night` in 1: night / flashing-mode request
- `NS` out 3: NS lamps {red, yellow, green} = bits [2:0]
- `EW` out 3: EW lamps, same encoding as `NS`
- `P_NS` out 3: NS pedestrian signal: 100 don't-walk, 010 clearance, 001 walk
- `P_EW` out 3: EW pedestrian signal, same encoding as `P_NS`
- `ped_ns_ack` out 1: one-cycle pulse when a pending NS request is granted
- `ped_ew_ack` out 1: one-cycle pulse when a pending EW request is granted

## Operation
- **States:** NS_G, NS_Y, AR_EW, EW_G, EW_Y, AR_NS, FLASH.
- **Cycle order:** NS_G → NS_Y → AR_EW → EW_G → EW_Y → AR_NS → NS_G.
- **Timer:** cleared on every state entry. The controller leaves a state when the timer reaches duration − 1. Each state therefore lasts exactly its parameter in cycles.
- **Lamps by state:**
  - NS_G: NS=001, EW=100
  - NS_Y: NS=010, EW=100
  - AR_*: NS=EW=100
  - EW_G / EW_Y: mirror of the NS states
- **Pending latches:**
  - `pend_ns` is set on any cycle with `ped_ns_req`=1.
  - It is cleared on entry to NS_G when it was set; that entry cycle pulses `ped_ns_ack`.
  - A request arriving during NS_G stays pending for the next NS_G. Set and clear in the same cycle leaves it set.
  - EW behaves the same way.
- **Served green (`served_ns`=1 for the whole NS_G):**
  - P_NS=001 for the first `WALK_T` cycles, then 010 for the remaining `GREEN_T − WALK_T` cycles.
- **P_NS outside a served green:** 100, including NS_Y, AR_* and unserved greens. EW behaves the same way.
- **Night mode:**
  - `night` is sampled only on the last cycle of AR_EW or AR_NS. If it is 1, the next state is FLASH instead of the green.
  - In FLASH, NS=EW=010 on even timer counts and 000 on odd counts, with a free-running 1-bit toggle. P_NS=P_EW=100.
  - Pending latches keep accumulating in FLASH. No acks are issued there.
  - When `night`=0 in FLASH, the next state is AR_NS with the timer cleared, then NS_G.
- Lamp outputs are registered and decoded from state, timer and the served flags. No green may ever be active on both roads.

## Timing
- **Reset (`res`=1):** asynchronous and immediate.
  - State → AR_NS, timer 0, pending latches and served flags 0, flash toggle 0.
  - NS=EW=100, P_NS=P_EW=100, acks 0.
- **First cycle after reset:** the first rising edge with `res`=0 is cycle 1 of AR_NS. NS_G begins at cycle `ALLRED_T`+1.
- **Full cycle length:** 2·(`GREEN_T`+`YELLOW_T`+`ALLRED_T`), which is 24 with the defaults.
- **Request-to-ack latency:** ≥1 cycle. A request registered at edge k can be acked at the earliest at edge k+1, and only if that edge enters NS_G.
- **`night` latency:** at most one full cycle plus `ALLRED_T`. Exit from FLASH takes `ALLRED_T` + 1 cycles to reach green.
- **Reset during a walk or FLASH:** immediate all-red and don't-walk. The pending request is lost.

## Test plan
- **Reset and sequence:** reset 2 cycles, defaults, release → NS_G on cycles 2–9, NS_Y 10–12, AR_EW 13, EW_G 14–21, EW_Y 22–24, AR_NS 25, NS_G again at 26. Both lamps never 001 simultaneously.
- **Pedestrian NS:** pulse `ped_ns_req` at cycle 15 → `ped_ns_ack` at cycle 26. P_NS=001 on cycles 26–29, 010 on 30–33, 100 from 34. The unserved NS_G at cycles 2–9 shows P_NS=100 throughout.
- **Request during own green:** `ped_ew_req` held through cycles 14–21 → no ack in that EW_G. Ack at cycle 38; the next EW_G shows walk on cycles 38–41.
- **Night:** `night`=1 from cycle 5 → FLASH from cycle 14, NS=EW toggling 010/000, P=100. Drop `night` at cycle 40 → AR_NS, then NS_G, at cycles 41 and 42.
- **Mid-walk reset:** assert `res` asynchronously, between edges, at cycle 27 of the pedestrian NS scenario → outputs 100/100/100/100 within the same cycle, before the next edge. After release the sequence restarts at AR_NS with no walk and no ack.
- **Parameter sweep:** `GREEN_T`=5, `YELLOW_T`=2, `ALLRED_T`=2, `WALK_T`=1 → cycle length 18, and each state lasts exactly its parameter.
